serial_adder: RTL
=================

# serial_adder

Bit-serial adder that wraps one instance of the existing single-bit full adder cell and adds two WIDTH-bit operands over WIDTH clock cycles, one bit per cycle, LSB first. It is the sequential stage directly around the full adder: it feeds the cell its `a`/`b`/`cin` bits from shift registers and consumes its `sum`/`cout` into a result register and a carry flop. It uses a start/done handshake so a controller or bench can launch additions back to back.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH ≥ 2.
- `clk`  input  1  rising-edge clock; the block has one clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to begin an addition; sampled only in IDLE or DONE.
- `a`  input  WIDTH  operand A; captured on an accepted start.
- `b`  input  WIDTH  operand B; captured on an accepted start.
- `cin`  input  1  carry-in; captured on an accepted start.
- `busy`  output  1  high while shifting.
- `done`  output  1  one-cycle pulse; `sum` and `cout` are valid.
- `sum`  output  WIDTH  result; held stable until the next accepted start.
- `cout`  output  1  final carry-out; held with `sum`.
- `ovf`  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - With `start`=1 at an edge, the block loads `a` into shift register RA and `b` into shift register RB.
  - It sets carry flop C to `cin`, clears bit counter N to 0, and goes to SHIFT.
  - With `start`=0 it stays in IDLE.
- **SHIFT, each cycle:**
  - The cell receives a=RA[0], b=RB[0], cin=C.
  - RA and RB shift right by 1 with zero fill.
  - The result register shifts right with the cell's `sum` entering the MSB.
  - C takes the cell's `cout`, and N increments.
  - When N = WIDTH-1 at the edge, that edge writes the last bit, sets `cout` to the cell's `cout`, and moves to DONE.
- **DONE:**
  - `done`=1 for this single cycle.
  - With `start`=1, the block loads the new operands exactly as in IDLE and goes to SHIFT, so back-to-back operation has no gap cycle.
  - Otherwise it goes to IDLE.
- **Start while busy:** `start` is ignored in SHIFT, and operands in flight are unaffected.
- **Holding:** `a`, `b` and `cin` are don't-care except at an accepted start.
- **Width rule:** the sum is modulo 2^WIDTH, and `cout` is the true bit WIDTH of a+b+cin.
- **N:** the counter is $clog2(WIDTH) bits wide and never wraps past WIDTH-1 within an operation.

## Timing
- **Reset:** all outputs reset to 0 (`busy`, `done`, `sum`, `cout`, `ovf`), the state goes to IDLE, and RA, RB, C and N clear. This takes effect immediately on `rst` rising, including mid-SHIFT, and the aborted operation produces no `done`.
- **Acceptance:** a start accepted at edge k drives `busy`=1 from edge k through edge k+WIDTH, for WIDTH cycles.
- **Completion:** `done`=1 and the final `sum`/`cout` are valid in the cycle after edge k+WIDTH. Latency from start to done is WIDTH cycles.
- **Intermediate values:** `sum` is not valid while `busy`=1, because its partial contents are visible; the bench checks `sum` only when `done` is high or afterwards.
- **Throughput:** one result per WIDTH+1 cycles when `start` is held high.

## Configuration
- **`SERIAL_ADDER_OVF_EN` defined:**
  - Adds the `ovf` port and a register for it.
  - On the final SHIFT edge, `ovf` takes C XOR the cell's `cout` (the carry into the MSB XOR the carry out of the MSB).
  - `ovf` is held with `sum` and reset to 0.
- **Undefined:** no `ovf` port and no register.

## Structure
- **Shared package `serial_adder_pkg`:**
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default width constant of 8.
- **Sub-module:** one instance of the existing `full_adder_behav` (ports a, b, cin, sum, cout). No other sub-modules.

## Test plan
- **Basic add:** WIDTH=8, a=0x5A, b=0x3C, cin=0. Required: `done` 8 cycles after start, `sum`=0x96, `cout`=0, `ovf`=1.
- **Carry-in and full carry chain:**
  - a=0xFF, b=0x01, cin=0. Required: `sum`=0x00, `cout`=1, `ovf`=0.
  - a=0x00, b=0x00, cin=1. Required: `sum`=0x01, `cout`=0.
- **Back-to-back:**
  - Stimulus: `start` held high, first a=0x80, b=0x80, then a=0x12, b=0x34.
  - Required for the first result: `sum`=0x00, `cout`=1, `ovf`=1.
  - Required for the second result: `sum`=0x46, `done` exactly 9 cycles after the first done, and `busy` low only during the DONE cycle.
- **Ignored start:** pulse `start` with a=0xFF, b=0xFF in the 3rd SHIFT cycle of an addition of 0x01+0x02. Required: `sum`=0x03, and no extra `done`.
- **Reset mid-operation:** assert `rst` in the 4th SHIFT cycle. Required: all outputs 0 at once, state IDLE, and no `done` until a new start. A new 0x0F+0x01 then yields 0x10.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder.
//   - DEFAULT_WIDTH : default operand/result width
//   - state_e       : controller state encoding (IDLE=0, SHIFT=1, DONE=2)
//   - cnt_width()   : bit counter width for a given operand width
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter must index bits 0..width-1; width is at least 2 so this is >= 1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_behav.sv
// full_adder_behav: single-bit combinational full adder cell.
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - majority(a, b, cin)
module full_adder_behav (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock, LSB first, built around
// a single full_adder_behav cell. Adds a + b + cin over WIDTH cycles with a
// start/done handshake; back-to-back starts are accepted in the DONE cycle.
//
// Parameters:
//   WIDTH  - operand/result width (>= 2)
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - launch request, honoured only in IDLE or DONE
//   a, b   - operands, captured on an accepted start
//   cin    - carry-in, captured on an accepted start
//   busy   - high while the operands are being shifted
//   done   - one-cycle pulse when sum/cout are final
//   sum    - result (partial contents visible while busy)
//   cout   - carry out of bit WIDTH-1
//   ovf    - signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf port and register.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit_c;

    // The one adder cell always looks at the current LSBs and the carry flop.
    full_adder_behav u_fa (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit_c = (n_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        res_d   = res_q;
        c_d     = c_q;
        n_d     = n_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    c_d     = cin;
                    n_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                ra_d  = {1'b0, ra_q[WIDTH-1:1]};
                rb_d  = {1'b0, rb_q[WIDTH-1:1]};
                res_d = {fa_sum, res_q[WIDTH-1:1]};
                c_d   = fa_cout;
                if (last_bit_c) begin
                    // Counter parks at WIDTH-1 instead of wrapping.
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // Carry into MSB differs from carry out of MSB.
                    ovf_d   = c_q ^ fa_cout;
`endif
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    n_d    = n_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            res_q   <= res_d;
            c_q     <= c_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = res_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
